// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder.
// DIRECT mode decodes indices taken over a valid/ready handshake.
// SCAN mode walks a single one across the outputs, holding each position for div+1 cycles.
module onehot_decoder_seq #(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned OUT_N = 8,
   parameter int unsigned DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel_in,
   input  logic             sel_valid,
   output logic             sel_ready,
   input  logic [DIV_W-1:0] div,
   output logic [OUT_N-1:0] onehot_out,
   output logic [SEL_W-1:0] idx_out,
   output logic             out_valid,
   output logic             err,
   output logic             frame_done
);

   typedef enum logic {
      S_DIRECT = 1'b0,
      S_SCAN   = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [DIV_W-1:0] presc, presc_d;
   logic [OUT_N-1:0] onehot_d;
   logic [SEL_W-1:0] idx_d;
   logic             valid_d, err_d, frame_d;
   // Set while disabled with a decoded value pending, so DIRECT can restore it on re-enable.
   logic             paused, paused_d;
   logic             accept;

   function automatic logic in_range(input logic [SEL_W-1:0] v);
      return 32'(v) < OUT_N;
   endfunction

   function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] v);
      logic [OUT_N-1:0] d;
      d = '0;
      for (int unsigned i = 0; i < OUT_N; i++) begin
         d[i] = (32'(v) == i);
      end
      return d;
   endfunction

   // Ready depends only on enable and mode, never on sel_valid.
   always_comb begin
      sel_ready = en & ~mode;
      accept    = sel_valid & sel_ready;
   end

   // Next-state and next-output selection.
   always_comb begin
      state_d  = state;
      presc_d  = presc;
      onehot_d = onehot_out;
      idx_d    = idx_out;
      valid_d  = out_valid;
      err_d    = err;
      frame_d  = 1'b0;
      paused_d = paused;

      if (!en) begin
         onehot_d = '0;
         valid_d  = 1'b0;
         paused_d = paused | out_valid;
      end else begin
         paused_d = 1'b0;
         state_d  = mode ? S_SCAN : S_DIRECT;
         if (mode) begin
            if (state == S_DIRECT) begin
               idx_d    = '0;
               onehot_d = decode('0);
               valid_d  = 1'b1;
               err_d    = 1'b0;
               presc_d  = '0;
            end else begin
               if (presc == div) begin
                  presc_d = '0;
                  if (32'(idx_out) == OUT_N - 1) begin
                     idx_d   = '0;
                     frame_d = 1'b1;
                  end else begin
                     idx_d = idx_out + 1'b1;
                  end
               end else begin
                  presc_d = presc + 1'b1;
               end
               onehot_d = decode(idx_d);
               valid_d  = 1'b1;
               err_d    = 1'b0;
            end
         end else if (accept) begin
            idx_d    = sel_in;
            onehot_d = decode(sel_in);
            valid_d  = 1'b1;
            err_d    = ~in_range(sel_in);
         end else if (paused) begin
            // Returning from a disable: rebuild the output from the frozen index.
            onehot_d = decode(idx_out);
            valid_d  = in_range(idx_out);
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_DIRECT;
         presc      <= '0;
         onehot_out <= '0;
         idx_out    <= '0;
         out_valid  <= 1'b0;
         err        <= 1'b0;
         frame_done <= 1'b0;
         paused     <= 1'b0;
      end else begin
         state      <= state_d;
         presc      <= presc_d;
         onehot_out <= onehot_d;
         idx_out    <= idx_d;
         out_valid  <= valid_d;
         err        <= err_d;
         frame_done <= frame_d;
         paused     <= paused_d;
      end
   end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. It generalises the fixed 3-to-8 combinational decoder in width and output count.
- Two modes:
  - DIRECT: decodes indices accepted over a valid/ready handshake.
  - SCAN: a walking one with a programmable dwell time, for multiplexed display and row strobing.
- Sits between control logic and enable or strobe lines in the digital-design blocks.

Parameters:
- SEL_W, 3, width of the binary index.
- OUT_N, 8, number of one-hot outputs. Legal range 2 to 2^SEL_W. Indices at or above OUT_N are out of range.
- DIV_W, 4, width of the SCAN dwell divider.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- sel_in  input  SEL_W  index to decode (DIRECT).
- sel_valid  input  1  sel_in is valid.
- sel_ready  output  1  block accepts sel_in this cycle.
- div  input  DIV_W  SCAN dwell: each position is held for div+1 cycles.
- onehot_out  output  OUT_N  registered one-hot output.
- idx_out  output  SEL_W  index currently driven.
- out_valid  output  1  onehot_out holds a decoded value.
- err  output  1  current index is out of range.
- frame_done  output  1  one-cycle pulse on SCAN wrap.

Behaviour:
- Reset: synchronous, active-high; overrides all other inputs in the same cycle.
  - Cleared on reset: onehot_out=0, idx_out=0, out_valid=0, err=0, frame_done=0, prescaler=0.
  - State after reset: S_DIRECT.
- States:
  - S_DIRECT entered when mode=0.
  - S_SCAN entered when mode=1.
  - The state register follows mode every cycle while en=1.
- sel_ready = en & ~mode. This path is combinational from en and mode only and never depends on sel_valid.
- DIRECT decode:
  - Accept condition: sel_valid & sel_ready.
  - On accept, the next cycle shows idx_out=sel_in and out_valid=1. Latency is 1 cycle.
  - In-range index (sel_in<OUT_N): onehot_out has only bit sel_in set; err=0.
  - Out-of-range index (sel_in>=OUT_N): onehot_out=0, err=1.
  - With no accept, all outputs hold their values.
  - Back-to-back accepts are legal; one index is decoded per cycle.
- SCAN entry:
  - Trigger: the first cycle with en=1 and mode=1 while the state is S_DIRECT.
  - Effect on the next cycle: idx_out=0, onehot_out=bit0, out_valid=1, err=0, prescaler=0.
- SCAN stepping:
  - The prescaler increments each enabled cycle.
  - When prescaler==div, the prescaler resets to 0 and idx_out advances by 1.
  - Wrap: from OUT_N-1, idx_out goes to 0 and frame_done pulses high for exactly that one cycle. This cycle is the one in which idx_out shows 0.
  - div=0 advances every cycle.
  - A change to div mid-dwell takes effect at the next compare; no reset of the prescaler.
  - idx_out never takes a value at or above OUT_N in SCAN, so err=0 throughout SCAN.
- Mode switch from SCAN to DIRECT:
  - Outputs hold the last scan position and out_valid stays 1.
  - sel_ready rises in the same cycle.
- en=0:
  - Next cycle: onehot_out=0 and out_valid=0.
  - idx_out, the prescaler and the state are frozen; err holds; frame_done=0.
  - sel_ready=0 and sel_valid is ignored.
- en re-asserted:
  - In SCAN, scanning resumes from the frozen idx_out and prescaler.
  - In DIRECT, the next cycle restores onehot_out from idx_out and sets out_valid=1 if idx_out<OUT_N.
- Reset mid-operation: reset wins over any accept or scan step in the same cycle; the next cycle shows the reset values.
- Mode changing in the same cycle as sel_valid: mode=1 gives sel_ready=0, so no accept occurs and SCAN entry happens instead.

Test Plan:
- Reset, then DIRECT with SEL_W=3, OUT_N=8: sel_in=0..7 back-to-back with sel_valid=1 -> one cycle later, onehot_out=01,02,04,...,80, out_valid=1, err=0.
- Out of range with SEL_W=3, OUT_N=6: sel_in=6, then sel_in=2 -> onehot_out=00 with err=1 and idx_out=6, then onehot_out=04 with err=0.
- SCAN with OUT_N=8 and div=2 -> each bit held for 3 cycles in order 01→02→...→80→01; frame_done pulses once every 24 cycles, coincident with idx_out=0.
- SCAN with div=0 and en dropped for 5 cycles at idx 3 -> onehot_out=0 and out_valid=0 during the drop; resumes at idx 4 the cycle after en returns.
- Mode switch at idx 5, then DIRECT sel_in=1 -> onehot_out holds 20 until the accept, then shows 02 one cycle later.
- rst asserted in the same cycle as a DIRECT accept of sel_in=4 -> next cycle: onehot_out=0, idx_out=0, out_valid=0; sel_ready=en&~mode.
